// File: rtl/oam_dma_ctrl.sv
// Single-port SRAM arbiter between the CPU MAR/MDR interface and an OAM DMA engine.
// A write to DMA_REG copies DMA_LEN bytes from {src_page,8'h00} to OAM_BASE, stalling the CPU meanwhile.
module oam_dma_ctrl #(
  parameter int unsigned DMA_LEN  = 160,
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter logic [15:0] DMA_REG  = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic        dma_busy
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    READ,
    WRITE
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state, state_next;
  logic [7:0] idx, idx_next;
  logic [7:0] dma_reg;
  logic [7:0] src_page;
  logic       rd_sel;
  logic       reg_hit, cpu_req, reg_wr, reg_rd;

  assign reg_hit = (cpu_addr == DMA_REG);
  assign cpu_req = cpu_re | cpu_we;
  // A simultaneous read+write is a write, so the register read path only sees pure reads.
  assign reg_wr  = cpu_we & reg_hit;
  assign reg_rd  = cpu_re & ~cpu_we & reg_hit;

  // Pages E0..FF mirror C0..DF (echo RAM).
  assign src_page = (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;

  assign dma_busy  = (state != IDLE);
  assign cpu_rdata = rd_sel ? dma_reg : mem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      dma_reg <= '0;
      rd_sel  <= 1'b0;
    end else begin
      idx    <= idx_next;
      rd_sel <= reg_rd;
      if (reg_wr) begin
        dma_reg <= cpu_wdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    cpu_stall  = 1'b0;

    case (state)
      IDLE: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (!reg_hit) begin
          mem_we = cpu_we;
          mem_re = cpu_re & ~cpu_we;
        end
      end
      START: begin
        state_next = READ;
      end
      READ: begin
        mem_addr   = {src_page, idx};
        mem_re     = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        mem_addr  = OAM_BASE + {8'h00, idx};
        mem_wdata = mem_rdata;
        mem_we    = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          idx_next   = idx + 8'd1;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (state != IDLE) begin
      cpu_stall = cpu_req & ~reg_hit;
    end

    // Restart overrides whatever the current step chose, including the final WRITE's return to IDLE.
    if (reg_wr) begin
      state_next = START;
      idx_next   = '0;
    end

    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      cpu_stall = 1'b0;
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: behavioural SRAM, write scoreboard for DMA copies,
// read-data queue for CPU reads.
module tb_oam_dma_ctrl;

  localparam int unsigned LEN = 160;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_re;
  logic        cpu_we;
  logic [7:0]  cpu_rdata;
  logic        cpu_stall;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic        dma_busy;

  oam_dma_ctrl #(
    .DMA_LEN (LEN),
    .OAM_BASE(16'hFE00),
    .DMA_REG (16'hFF46)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_re   (cpu_re),
    .cpu_we   (cpu_we),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata),
    .dma_busy (dma_busy)
  );

  always #5 clk = ~clk;

  logic [7:0] sram [0:65535];
  logic [7:0] rdq = 8'h00;
  assign mem_rdata = rdq;

  always @(posedge clk) begin
    if (mem_re) rdq <= sram[mem_addr];
    if (mem_we) sram[mem_addr] = mem_wdata;
  end

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  rd_exp[$];
  logic [23:0] wr_exp[$];
  int unsigned busy_cnt, writes_seen, stall_bad, guard, mism;
  logic        hold, restarted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [15:0] src);
    wr_exp.delete();
    for (int unsigned i = 0; i < LEN; i++)
      wr_exp.push_back({16'hFE00 + 16'(i), sram[src + 16'(i)]});
  endtask

  // Samples one cycle of a running transfer, then advances to the next cycle.
  task automatic dma_cycle();
    logic [23:0] e;
    if (dma_busy) busy_cnt++;
    if (mem_we) begin
      chk("dma_wr_expected", 32'(wr_exp.size() > 0), 32'd1);
      if (wr_exp.size() > 0) begin
        e = wr_exp.pop_front();
        chk("dma_wr", {8'h00, mem_addr, mem_wdata}, {8'h00, e});
      end
      writes_seen++;
    end
    if (hold && dma_busy) begin
      if (cpu_stall !== 1'b1 || (mem_re && mem_addr == 16'hD000)) stall_bad++;
    end
    tick();
  endtask

  task automatic start_dma(input logic [7:0] page);
    cpu_addr  = 16'hFF46;
    cpu_wdata = page;
    cpu_we    = 1'b1;
    cpu_re    = 1'b0;
    #1;
    chk("dmareg_wr_internal", {29'h0, mem_re, mem_we, cpu_stall}, 32'h0);
    tick();
    cpu_we = 1'b0;
    #1;
    busy_cnt    = 0;
    writes_seen = 0;
    stall_bad   = 0;
    guard       = 0;
    restarted   = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] expv);
    cpu_addr = a;
    cpu_re   = 1'b1;
    #1;
    rd_exp.push_back(expv);
    tick();
    cpu_re = 1'b0;
    #1;
    chk(tag, {24'h0, cpu_rdata}, {24'h0, rd_exp.pop_front()});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int unsigned i = 0; i < 256; i++) begin
      sram[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
      sram[16'hC100 + 16'(i)] = ~8'(i);
      sram[16'hD000 + 16'(i)] = 8'(i * 3 + 1);
      sram[16'hE100 + 16'(i)] = 8'hEE;
      sram[16'hFE00 + 16'(i)] = 8'h00;
    end
    sram[16'hA123] = 8'h00;
    hold      = 1'b0;
    restarted = 1'b0;
    rst       = 1'b1;
    cpu_addr  = 16'hC000;
    cpu_wdata = 8'h77;
    cpu_re    = 1'b1;
    cpu_we    = 1'b0;

    // Reset state, with a CPU read held so the output gating is visible.
    tick();
    tick();
    chk("rst_mem_re", {31'h0, mem_re}, 32'h0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_busy_stall", {30'h0, dma_busy, cpu_stall}, 32'h0);
    cpu_re = 1'b0;
    rst    = 1'b0;
    tick();

    // 1: plain read passthrough.
    cpu_addr = 16'hC000;
    cpu_re   = 1'b1;
    #1;
    chk("t1_mem_re", {31'h0, mem_re}, 32'h1);
    chk("t1_mem_addr", {16'h0, mem_addr}, 32'hC000);
    chk("t1_stall", {31'h0, cpu_stall}, 32'h0);
    cpu_re = 1'b0;
    cpu_read("t1_rdata", 16'hC000, sram[16'hC000]);

    // Read+write together behaves as a write.
    cpu_addr  = 16'hA123;
    cpu_wdata = 8'h3C;
    cpu_re    = 1'b1;
    cpu_we    = 1'b1;
    #1;
    chk("rw_mem_en", {30'h0, mem_re, mem_we}, 32'h1);
    chk("rw_mem_wdata", {24'h0, mem_wdata}, 32'h3C);
    tick();
    cpu_re = 1'b0;
    cpu_we = 1'b0;
    #1;
    chk("rw_sram", {24'h0, sram[16'hA123]}, 32'h3C);

    // 2 + 3: full copy from C0 with a CPU read stalled through it.
    load_exp(16'hC000);
    start_dma(8'hC0);
    while (dma_busy && guard < 2000) begin
      if (guard == 10) begin
        cpu_addr = 16'hD000;
        cpu_re   = 1'b1;
        hold     = 1'b1;
        #1;
      end
      dma_cycle();
      guard++;
    end
    chk("t2_busy_cycles", busy_cnt, 321);
    chk("t2_writes_left", wr_exp.size(), 0);
    chk("t3_stall", stall_bad, 0);
    chk("t3_accept", {15'h0, cpu_stall, mem_re, mem_addr}, {15'h0, 1'b0, 1'b1, 16'hD000});
    hold = 1'b0;
    cpu_read("t3_rdata", 16'hD000, sram[16'hD000]);
    mism = 0;
    for (int unsigned i = 0; i < LEN; i++)
      if (sram[16'hFE00 + 16'(i)] !== sram[16'hC000 + 16'(i)]) mism++;
    chk("t2_oam_copy", mism, 0);

    // 4: register read mid-transfer, then restart from D0 at idx 50.
    load_exp(16'hC000);
    start_dma(8'hC0);
    while (dma_busy && guard < 2000) begin
      if (guard == 20) begin
        cpu_addr = 16'hFF46;
        cpu_re   = 1'b1;
        #1;
        chk("t4_reg_rd_stall", {31'h0, cpu_stall}, 32'h0);
        rd_exp.push_back(8'hC0);
      end else if (guard == 21) begin
        cpu_re = 1'b0;
        #1;
        chk("t4_reg_rdata", {24'h0, cpu_rdata}, {24'h0, rd_exp.pop_front()});
      end else if (!restarted && writes_seen == 50) begin
        chk("t4_read_idx50", {15'h0, mem_re, mem_addr}, {15'h0, 1'b1, 16'hC032});
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hD0;
        cpu_we    = 1'b1;
        #1;
        chk("t4_restart_stall", {31'h0, cpu_stall}, 32'h0);
        restarted = 1'b1;
        dma_cycle();
        cpu_we = 1'b0;
        load_exp(16'hD000);
        writes_seen = 0;
        busy_cnt    = 0;
        guard++;
        continue;
      end
      dma_cycle();
      guard++;
    end
    chk("t4_busy_cycles", busy_cnt, 321);
    chk("t4_writes", writes_seen, LEN);
    chk("t4_writes_left", wr_exp.size(), 0);

    // Restart landing on the final WRITE, new page E1 (mirrors to C1).
    load_exp(16'hC000);
    start_dma(8'hC0);
    while (dma_busy && guard < 2000) begin
      if (!restarted && mem_we && wr_exp.size() == 1) begin
        cpu_addr  = 16'hFF46;
        cpu_wdata = 8'hE1;
        cpu_we    = 1'b1;
        #1;
        dma_cycle();
        chk("t5_final_write_done", wr_exp.size(), 0);
        chk("t5_restart_busy", {31'h0, dma_busy}, 32'h1);
        cpu_we = 1'b0;
        load_exp(16'hC100);
        busy_cnt  = 0;
        restarted = 1'b1;
        guard++;
        continue;
      end
      dma_cycle();
      guard++;
    end
    chk("t5_restarted", {31'h0, restarted}, 32'h1);
    chk("t5_busy_cycles", busy_cnt, 321);
    chk("t5_writes_left", wr_exp.size(), 0);

    // 6: reset at idx 80 aborts; upper half of OAM keeps the C1 copy.
    load_exp(16'hC000);
    start_dma(8'hC0);
    while (dma_busy && guard < 2000 && writes_seen < 80) begin
      dma_cycle();
      guard++;
    end
    rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", {28'h0, mem_re, mem_we, cpu_stall, dma_busy}, 32'h0);
    chk("t6_rst_addr", {8'h0, mem_addr, mem_wdata}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    wr_exp.delete();
    mism = 0;
    for (int unsigned i = 0; i < 80; i++)
      if (sram[16'hFE00 + 16'(i)] !== sram[16'hC000 + 16'(i)]) mism++;
    chk("t6_oam_low", mism, 0);
    mism = 0;
    for (int unsigned i = 80; i < LEN; i++)
      if (sram[16'hFE00 + 16'(i)] !== sram[16'hC100 + 16'(i)]) mism++;
    chk("t6_oam_high_kept", mism, 0);
    cpu_addr = 16'hC000;
    cpu_re   = 1'b1;
    #1;
    chk("t6_cpu_pass", {30'h0, cpu_stall, mem_re}, 32'h1);
    cpu_re = 1'b0;
    cpu_read("t6_rdata", 16'hC000, sram[16'hC000]);
    cpu_read("t6_dmareg_cleared", 16'hFF46, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
